// File: rtl/stream_demux_1ton.sv
// stream_demux_1ton: registered 1-to-N stream demultiplexer.
// Each input beat goes to the output channel named by in_sel, or to every
// channel when in_bcast is set. Every output channel is a one-entry
// valid/ready register that can pass a new beat through in the same cycle
// it drains the old one. Beats addressed past the last channel are dropped
// and counted in a saturating counter.
module stream_demux_1ton #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = 2,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_bcast,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [CNT_W-1:0]   drop_count
);

  // Registered output stage: one data/valid slot per channel.
  logic [N*WIDTH-1:0] data_p1;
  logic [N-1:0]       vld_p1;
  logic [CNT_W-1:0]   drop_cnt_p1;

  // Input-side decode.
  logic [N-1:0] free;
  logic [N-1:0] sel_hit;
  logic [N-1:0] load;
  logic         in_range;
  logic         accept;
  logic         drop;

  // Counter increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // One-hot decode of the select; stays all-zero when in_sel names no channel.
  always_comb begin
    sel_hit = '0;
    for (int k = 0; k < N; k++) begin
      sel_hit[k] = (in_sel == SEL_W'(k));
    end
  end

  // Readiness and load enables. A slot is free when it is empty or draining
  // this cycle; broadcast needs every slot free so it is never split.
  always_comb begin
    free     = ~vld_p1 | out_ready;
    in_range = |sel_hit;
    if (in_bcast) begin
      in_ready = &free;
    end else if (in_range) begin
      in_ready = |(sel_hit & free);
    end else begin
      in_ready = 1'b1;
    end
    accept = in_valid & in_ready;
    load   = '0;
    if (accept) begin
      load = in_bcast ? {N{1'b1}} : sel_hit;
    end
    drop = accept & ~in_bcast & ~in_range;
  end

  // ---- stage p1: per-channel slot update and drop counting ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= '0;
      data_p1     <= '0;
      drop_cnt_p1 <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (load[k]) begin
          vld_p1[k]                  <= 1'b1;
          data_p1[k*WIDTH +: WIDTH]  <= in_data;
        end else if (out_ready[k]) begin
          vld_p1[k]                  <= 1'b0;
        end
      end
      if (drop) begin
        drop_cnt_p1 <= sat_inc(drop_cnt_p1);
      end
    end
  end

  assign out_data   = data_p1;
  assign out_valid  = vld_p1;
  assign drop_count = drop_cnt_p1;

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Bench for stream_demux_1ton: a 4-channel instance driven from a vector
// table and hand sequences with a per-channel scoreboard, plus a 3-channel
// instance with a 2-bit drop counter for out-of-range selects.
module tb_stream_demux_1ton;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_bcast;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [7:0]  drop_count;

  logic [1:0]  d3_sel;
  logic        d3_valid;
  logic        d3_in_ready;
  logic [23:0] d3_out_data;
  logic [2:0]  d3_out_valid;
  logic [1:0]  d3_drop;

  int n_cmp = 0;
  int n_bad = 0;

  stream_demux_1ton #(.WIDTH(8), .N(4), .SEL_W(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
    .in_bcast(in_bcast), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .drop_count(drop_count)
  );

  stream_demux_1ton #(.WIDTH(8), .N(3), .SEL_W(2), .CNT_W(2)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(d3_sel),
    .in_bcast(1'b0), .in_valid(d3_valid), .in_ready(d3_in_ready),
    .out_data(d3_out_data), .out_valid(d3_out_valid), .out_ready(3'b111),
    .drop_count(d3_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: expected contents of each channel slot, in acceptance order.
  logic [7:0] sb [4][$];
  logic [3:0] mon_free;
  logic       mon_rdy;

  // Monitor on the falling edge: compare slots against the scoreboard,
  // retire beats the consumer takes, record beats the block accepts.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) sb[k].delete();
    end else begin
      for (int k = 0; k < 4; k++) begin
        mon_free[k] = (sb[k].size() == 0) || out_ready[k];
      end
      mon_rdy = in_bcast ? (&mon_free) : mon_free[in_sel];
      chk("in_ready model", 32'(in_ready), 32'(mon_rdy));
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("ch%0d valid", k), 32'(out_valid[k]), 32'(sb[k].size() != 0));
        if (out_valid[k] && sb[k].size() != 0) begin
          chk($sformatf("ch%0d data", k), 32'(out_data[k*8 +: 8]), 32'(sb[k][0]));
          if (out_ready[k]) void'(sb[k].pop_front());
        end
      end
      if (in_valid && in_ready) begin
        if (in_bcast) begin
          for (int k = 0; k < 4; k++) sb[k].push_back(in_data);
        end else begin
          sb[in_sel].push_back(in_data);
        end
      end
    end
  end

  typedef struct {
    logic       v;
    logic       b;
    logic [1:0] s;
    logic [7:0] d;
    logic [3:0] r;
    logic       er;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];
  int   exp_drop [5];

  initial begin
    // unicast routing, one beat per channel back to back
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 8'h10, 4'hF, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 2'd1, 8'h21, 4'hF, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 2'd2, 8'h32, 4'hF, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 2'd3, 8'h43, 4'hF, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 2'd0, 8'h00, 4'hF, 1'b1};
    // backpressure on channel 2
    tbl[5]  = '{1'b1, 1'b0, 2'd2, 8'h55, 4'hB, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 2'd2, 8'h66, 4'hB, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 2'd2, 8'h66, 4'hB, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 2'd0, 8'h77, 4'hB, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 2'd2, 8'h66, 4'hF, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'hF, 1'b1};
    // broadcast blocked by a stalled channel 3, then released
    tbl[11] = '{1'b1, 1'b0, 2'd3, 8'h99, 4'h7, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 2'd0, 8'hBC, 4'h7, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 2'd2, 8'hBC, 4'h7, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 2'd0, 8'hBC, 4'hF, 1'b1};
    exp_drop = '{1, 2, 3, 3, 3};

    // reset held for two cycles with a beat presented
    rst = 1'b1; in_valid = 1'b1; in_sel = 2'd1; in_data = 8'hA5;
    in_bcast = 1'b0; out_ready = 4'h0; d3_valid = 1'b0; d3_sel = 2'd0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("reset out_valid", 32'(out_valid), 32'h0);
      chk("reset drop_count", 32'(drop_count), 32'h0);
      chk("reset out_data", out_data, 32'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post-reset out_valid", 32'(out_valid), 32'h2);
    chk("post-reset ch1 data", 32'(out_data[15:8]), 32'hA5);

    // table-driven sequence
    for (int i = 0; i < NV; i++) begin
      in_valid = tbl[i].v; in_bcast = tbl[i].b; in_sel = tbl[i].s;
      in_data = tbl[i].d; out_ready = tbl[i].r;
      @(negedge clk);
      chk($sformatf("in_ready row %0d", i), 32'(in_ready), 32'(tbl[i].er));
      @(posedge clk); #1;
    end
    chk("bcast out_valid", 32'(out_valid), 32'hF);
    chk("bcast out_data", out_data, 32'hBCBCBCBC);

    // hold everything, then reset mid-stream
    in_valid = 1'b0; in_bcast = 1'b0; out_ready = 4'h0;
    @(posedge clk); #1;
    chk("held out_valid", 32'(out_valid), 32'hF);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid-reset out_valid", 32'(out_valid), 32'h0);
    chk("mid-reset out_data", out_data, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("after mid-reset out_valid", 32'(out_valid), 32'h0);

    // out-of-range selects on the 3-channel instance
    d3_valid = 1'b1; d3_sel = 2'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("drop in_ready %0d", i), 32'(d3_in_ready), 32'h1);
      @(posedge clk); #1;
      chk($sformatf("drop_count %0d", i), 32'(d3_drop), 32'(exp_drop[i]));
      chk($sformatf("drop out_valid %0d", i), 32'(d3_out_valid), 32'h0);
    end
    d3_valid = 1'b0;
    chk("main drop_count", 32'(drop_count), 32'h0);

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_demux_1ton.md
Name: stream_demux_1ton

Overview:
- Parametrised 1-to-N stream demultiplexer. It is the registered, handshaked successor of the combinational 1x2 demux.
- Routes each input beat to one of N output channels, or to all of them in broadcast mode.
- Each output channel holds a one-entry valid/ready register.
- Beats whose select is out of range are dropped and counted. The block sits between a single producer and N independent consumers.

Parameters:
- WIDTH, 8: data width in bits.
- N, 4: number of output channels. Legal range is 2..2^SEL_W.
- SEL_W, 2: select width.
- CNT_W, 8: drop counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  input beat data.
- in_sel  input  SEL_W  destination channel index.
- in_bcast  input  1  1 = deliver the beat to all N channels; in_sel is ignored.
- in_valid  input  1  input beat present.
- in_ready  output  1  block can accept the beat this cycle.
- out_data  output  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- out_valid  output  N  per-channel valid.
- out_ready  input  N  per-channel consumer ready.
- drop_count  output  CNT_W  number of dropped beats; saturates.

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is synchronous and active-high. On a rst=1 edge:
  - out_valid = 0, out_data = 0, drop_count = 0.
  - rst overrides any transfer in the same cycle.
  - Reset mid-stream discards all held beats without delivering them.
- Per-channel state: each channel is EMPTY (out_valid=0) or FULL (out_valid=1).
  - EMPTY to FULL on a load.
  - FULL to EMPTY when out_ready=1 and there is no load.
  - FULL to FULL with new data when out_ready=1 and a load occurs in the same cycle (pass-through). This sustains 1 beat/cycle per channel.
  - FULL and out_ready=0: data and valid are held stable and must not change.
- Slot free: free[k] = ~out_valid[k] | out_ready[k].
- in_ready is combinational, with no dependency on in_valid:
  - in_bcast=1: AND of free[0..N-1].
  - in_bcast=0 and in_sel<N: free[in_sel].
  - in_bcast=0 and in_sel>=N: 1 (drop path is always ready).
- Accept: transfer occurs when in_valid & in_ready at a clock edge.
  - Unicast with in_sel<N: load channel in_sel only.
  - Broadcast: load every channel with the same in_data.
  - Unicast with in_sel>=N: no channel loaded; drop_count increments by 1. It saturates at 2^CNT_W-1 and does not wrap.
- Latency: an accepted beat appears on out_valid/out_data on the cycle after acceptance (1-cycle latency).
- Isolation: channels not loaded keep their contents. A stalled channel never blocks unicast traffic to other channels.
- Broadcast atomicity: a broadcast beat is never partially delivered. It waits until every channel is free.
- Ordering: per channel, beats are delivered in acceptance order.
- No input buffering: in_data and in_sel are sampled only on the accepting edge. If in_valid=0, no state changes except output drains.
- Out-of-range select: only reachable when N < 2^SEL_W. It must not alter any out_valid.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst for 2 cycles with in_valid=1, in_sel=1, in_data=8'hA5.
  - Required: out_valid=4'b0000 and drop_count=0 throughout reset.
  - Required: after release, channel 1 shows A5 one cycle later.
- Unicast routing:
  - Stimulus: out_ready=4'b1111; send data 8'h10, 8'h21, 8'h32, 8'h43 to sel 0..3 on consecutive cycles.
  - Required: each beat appears once, on only its channel, 1 cycle after acceptance; in_ready stays 1.
- Backpressure isolation:
  - Stimulus: out_ready[2]=0; send 8'h55 to ch2, then 8'h66 to ch2, then 8'h77 to ch0.
  - Required: ch2 holds 55 stably; in_ready=0 while 66 targets ch2, so 66 is not lost. Pass-through fires on the ready cycle.
  - Required: once the stalled beat is withdrawn, 77 reaches ch0.
  - Required: raising out_ready[2] delivers 55 and then 66 in order.
- Broadcast atomicity:
  - Stimulus: out_valid[3]=1 with out_ready[3]=0; send in_bcast=1, data 8'hBC.
  - Required: in_ready=0 and no channel loads.
  - Required: after out_ready[3]=1, all four channels show BC on the same cycle.
- Drop counter saturation:
  - Stimulus: N=3, SEL_W=2, CNT_W=2; send 5 beats with in_sel=3.
  - Required: in_ready=1 each cycle; drop_count goes 1, 2, 3, 3, 3; out_valid stays 0.
- Reset mid-operation:
  - Stimulus: fill all channels with out_ready=0, then pulse rst.
  - Required: out_valid=0 on the next cycle; held data is never presented.
